stack_ctrl: RTL and testbench

//  Initiator-side controller for the STACK memory block. Accepts push/pop/clear

---
 rtl/stack_ctrl.sv | 114 +++++++++++
 tb/tb_stack_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/stack_ctrl.sv
// Initiator-side controller for the STACK memory block: owns the stack pointer,
// sequences push/pop/clear requests onto the stack strobes and returns responses.
module stack_ctrl #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              stk_push_enable,
  output logic              stk_pop_enable,
  output logic              stk_read_enable,
  output logic [DATA_W-1:0] stk_data_in,
  output logic [DATA_W-1:0] stk_sp_in,
  input  logic [DATA_W-1:0] stk_data_out,
  input  logic [DATA_W-1:0] stk_sp_out,
  output logic [DATA_W-1:0] depth,
  output logic              full,
  output logic              empty,
  output logic              sp_mismatch
);

  localparam logic [1:0] OP_PUSH  = 2'b00;
  localparam logic [1:0] OP_POP   = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;
  localparam logic [DATA_W-1:0] DEPTH_W = DATA_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPT, RESP} state_t;

  state_t            state_q, state_d;
  logic [1:0]        op_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] sp_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_err_q;
  logic              mismatch_q;
  logic              idle_prev_q;
  logic              accept;
  logic              bad_req;

  assign full    = (sp_q == DEPTH_W);
  assign empty   = (sp_q == '0);
  assign accept  = req_valid && (state_q == IDLE);
  assign bad_req = ((req_op == OP_PUSH) && full) || ((req_op == OP_POP) && empty)
                   || (req_op == OP_RSVD);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = bad_req ? RESP : ISSUE;
      ISSUE: state_d = (op_q == OP_POP) ? CAPT : RESP;
      CAPT:  state_d = RESP;
      RESP:  if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= OP_PUSH;
      data_q      <= '0;
      sp_q        <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      mismatch_q  <= 1'b0;
      idle_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idle_prev_q <= (state_q == IDLE);
      if (accept) begin
        op_q       <= req_op;
        data_q     <= req_data;
        rsp_data_q <= '0;
        rsp_err_q  <= bad_req;
      end
      if (state_q == ISSUE) begin
        unique case (op_q)
          OP_PUSH:  sp_q <= sp_q + 1'b1;
          OP_POP:   sp_q <= sp_q - 1'b1;
          OP_CLEAR: sp_q <= '0;
          default:  sp_q <= sp_q;
        endcase
      end
      if (state_q == CAPT) rsp_data_q <= stk_data_out;
      // The STACK's own SP may lag one cycle behind a clear, so only compare
      // once IDLE has been held for a second consecutive cycle.
      if ((state_q == IDLE) && idle_prev_q && (stk_sp_out != sp_q)) mismatch_q <= 1'b1;
    end
  end

  // Strobes are gated by reset so an aborted ISSUE never reaches the STACK.
  assign stk_push_enable = (state_q == ISSUE) && (op_q == OP_PUSH) && !reset;
  assign stk_pop_enable  = (state_q == ISSUE) && (op_q == OP_POP) && !reset;
  assign stk_read_enable = 1'b0;
  assign stk_data_in     = data_q;
  assign stk_sp_in       = sp_q;

  assign req_ready   = (state_q == IDLE);
  assign rsp_valid   = (state_q == RESP);
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign depth       = sp_q;
  assign sp_mismatch = mismatch_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Scoreboard bench for stack_ctrl with a behavioural STACK model behind the strobes.
module tb_stack_ctrl;
  localparam int DW = 32;
  localparam int DP = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_op = 2'b00;
  logic [DW-1:0] req_data = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic          stk_push_enable, stk_pop_enable, stk_read_enable;
  logic [DW-1:0] stk_data_in, stk_sp_in, stk_data_out, stk_sp_out, depth;
  logic          full, empty, sp_mismatch;

  stack_ctrl #(.DATA_W(DW), .DEPTH(DP)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .stk_push_enable(stk_push_enable), .stk_pop_enable(stk_pop_enable),
    .stk_read_enable(stk_read_enable), .stk_data_in(stk_data_in), .stk_sp_in(stk_sp_in),
    .stk_data_out(stk_data_out), .stk_sp_out(stk_sp_out),
    .depth(depth), .full(full), .empty(empty), .sp_mismatch(sp_mismatch)
  );

  always #5 clk = ~clk;

  // Behavioural STACK: write at sp_in on push, read sp_in-1 on pop; sp_out follows.
  logic [DW-1:0] mem [DP];
  logic [DW-1:0] m_sp, m_dout;
  logic [DW-1:0] sp_bias = '0;
  always @(posedge clk) begin
    if (reset) begin
      m_sp <= '0; m_dout <= '0;
    end else if (stk_push_enable) begin
      mem[stk_sp_in[5:0]] <= stk_data_in;
      m_sp <= stk_sp_in + 1;
    end else if (stk_pop_enable) begin
      m_dout <= mem[6'(stk_sp_in - 1)];
      m_sp <= stk_sp_in - 1;
    end else begin
      m_sp <= stk_sp_in;
    end
  end
  assign stk_data_out = m_dout;
  assign stk_sp_out   = m_sp + sp_bias;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Strobe monitor
  int push_cnt = 0, pop_cnt = 0, overlap_cnt = 0, read_cnt = 0;
  logic [DW-1:0] last_sp_in = '0, last_din = '0;
  always @(negedge clk) begin
    if (stk_push_enable && stk_pop_enable) overlap_cnt++;
    if (stk_read_enable) read_cnt++;
    if (stk_push_enable) begin
      push_cnt++; last_sp_in = stk_sp_in; last_din = stk_data_in;
    end
    if (stk_pop_enable) pop_cnt++;
  end

  // Response scoreboard: {err, data}
  logic [DW:0] exp_q [$];
  always @(negedge clk) begin
    if (!reset && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
      end else begin
        logic [DW:0] e;
        e = exp_q.pop_front();
        chk("rsp_data", 64'(rsp_data), 64'(e[DW-1:0]));
        chk("rsp_err", 64'(rsp_err), 64'(e[DW]));
      end
    end
  end

  task automatic do_req(input logic [1:0] op, input logic [DW-1:0] data, input logic eerr,
                        input logic [DW-1:0] edata, input int elat, input int hold);
    int lat, n;
    logic [DW-1:0] d0;
    logic stable;
    exp_q.push_back({eerr, edata});
    @(negedge clk);
    if (hold > 0) rsp_ready = 1'b0;
    req_valid = 1'b1; req_op = op; req_data = data;
    chk("req_ready_idle", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_data = '0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    chk("latency", 64'(lat), 64'(elat));
    if (hold > 0) begin
      d0 = rsp_data; stable = 1'b1;
      repeat (hold) begin
        @(posedge clk); #1;
        if (!rsp_valid || rsp_data !== d0 || req_ready !== 1'b0) stable = 1'b0;
      end
      chk("hold_stable", 64'(stable), 64'd1);
      rsp_ready = 1'b1;
    end
    n = 0;
    while (rsp_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("rsp_release", 64'(rsp_valid), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_depth", 64'(depth), 64'd0);
    chk("rst_flags", {60'd0, rsp_valid, req_ready, empty, sp_mismatch}, 64'b0110);
  endtask

  initial begin
    int pc, oc;
    do_reset();
    chk("rst_rsp", {31'd0, rsp_err, rsp_data}, 64'd0);

    // 1: single push
    pc = push_cnt;
    do_req(2'b00, 32'hA5A5_0001, 1'b0, '0, 2, 0);
    chk("t1_push_strobes", 64'(push_cnt - pc), 64'd1);
    chk("t1_sp_in", 64'(last_sp_in), 64'd0);
    chk("t1_data_in", 64'(last_din), 64'hA5A5_0001);
    chk("t1_depth", 64'(depth), 64'd1);

    // 2: LIFO ordering
    do_reset();
    do_req(2'b00, 32'h11, 1'b0, '0, 2, 0);
    do_req(2'b00, 32'h22, 1'b0, '0, 2, 0);
    do_req(2'b00, 32'h33, 1'b0, '0, 2, 0);
    do_req(2'b01, '0, 1'b0, 32'h33, 3, 0);
    do_req(2'b01, '0, 1'b0, 32'h22, 3, 0);
    do_req(2'b01, '0, 1'b0, 32'h11, 3, 0);
    chk("t2_empty", 64'(empty), 64'd1);

    // 3: underflow and reserved op
    oc = pop_cnt;
    do_req(2'b01, '0, 1'b1, '0, 1, 0);
    chk("t3_no_pop", 64'(pop_cnt - oc), 64'd0);
    chk("t3_depth", 64'(depth), 64'd0);
    do_req(2'b11, 32'hDEAD, 1'b1, '0, 1, 0);
    chk("t3_rsvd_depth", 64'(depth), 64'd0);

    // 4: fill to capacity, overflow, pop top
    for (int i = 0; i < DP; i++) do_req(2'b00, 32'h1000 + 32'(i), 1'b0, '0, 2, 0);
    chk("t4_full", {62'd0, full, empty}, 64'b10);
    chk("t4_depth", 64'(depth), 64'(DP));
    pc = push_cnt;
    do_req(2'b00, 32'hBAD, 1'b1, '0, 1, 0);
    chk("t4_no_push", 64'(push_cnt - pc), 64'd0);
    chk("t4_depth_hold", 64'(depth), 64'(DP));
    do_req(2'b01, '0, 1'b0, 32'h103F, 3, 0);
    chk("t4_depth_after_pop", 64'(depth), 64'(DP - 1));

    // 5: clear
    do_reset();
    for (int i = 0; i < 5; i++) do_req(2'b00, 32'h50 + 32'(i), 1'b0, '0, 2, 0);
    do_req(2'b10, 32'hFFFF, 1'b0, '0, 2, 0);
    repeat (3) @(negedge clk);
    chk("t5_depth", 64'(depth), 64'd0);
    chk("t5_mismatch", 64'(sp_mismatch), 64'd0);
    do_req(2'b01, '0, 1'b1, '0, 1, 0);

    // 6: response backpressure, then reset during ISSUE
    do_reset();
    do_req(2'b00, 32'h77, 1'b0, '0, 2, 0);
    do_req(2'b01, '0, 1'b0, 32'h77, 3, 10);
    do_req(2'b00, 32'h88, 1'b0, '0, 2, 0);
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b01;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b1;
    oc = pop_cnt;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("t6_abort_no_pop", 64'(pop_cnt - oc), 64'd0);
    chk("t6_abort_state", {61'd0, req_ready, rsp_valid, sp_mismatch}, 64'b100);
    chk("t6_abort_depth", 64'(depth), 64'd0);

    // SP coherence: a disagreeing STACK SP sets a sticky flag
    repeat (3) @(negedge clk);
    chk("coh_clean", 64'(sp_mismatch), 64'd0);
    sp_bias = 32'd1;
    repeat (3) @(negedge clk);
    chk("coh_detect", 64'(sp_mismatch), 64'd1);
    sp_bias = '0;
    repeat (3) @(negedge clk);
    chk("coh_sticky", 64'(sp_mismatch), 64'd1);
    do_reset();

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    chk("strobe_overlap", 64'(overlap_cnt), 64'd0);
    chk("read_enable_low", 64'(read_cnt), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end
endmodule
